// File: rtl/trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the machine-mode trap sequencer:
//   - CSR addresses touched by the sequencer
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - default mcause values and the direct-mode mtvec mask
//   - sequencer state and sequence-kind enumerations
// ---------------------------------------------------------------------------
package trap_ctrl_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    // Privilege encodings written into MPP
    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    // Default mcause values
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;        // environment call from M-mode
    localparam logic [31:0] CAUSE_MTIMER  = 32'h8000_0007; // machine timer interrupt

    // Direct-mode trap vector: low two bits of mtvec are the mode field
    localparam logic [31:0] MTVEC_DIRECT_MASK = 32'hFFFF_FFFC;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_EPC   = 3'd1,
        W_CAUSE = 3'd2,
        W_STAT  = 3'd3,
        REDIR   = 3'd4
    } trap_state_e;

    // Which kind of sequence is in flight
    typedef enum logic {
        KIND_TRAP = 1'b0,
        KIND_RET  = 1'b1
    } trap_kind_e;

endpackage : trap_ctrl_pkg

// File: rtl/trap_mstatus_upd.sv
// ---------------------------------------------------------------------------
// trap_mstatus_upd
// Purely combinational mstatus rewrite used in the W_STAT step.
//   Trap entry : MPIE <- MIE, MIE <- 0, MPP <- M
//   Trap return: MIE <- MPIE, MPIE <- 1, MPP <- U
// All other bits pass through unchanged.
// Ports:
//   mstatus_i  in  XLEN  current mstatus
//   kind_i     in  1     KIND_TRAP or KIND_RET
//   mstatus_o  out XLEN  updated mstatus
// ---------------------------------------------------------------------------
module trap_mstatus_upd
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mstatus_i,
    input  trap_kind_e      kind_i,
    output logic [XLEN-1:0] mstatus_o
);

    always_comb begin
        mstatus_o = mstatus_i;
        if (kind_i == KIND_TRAP) begin
            mstatus_o[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
            mstatus_o[MSTATUS_MIE]                   = 1'b0;
            mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        end else begin
            mstatus_o[MSTATUS_MIE]                   = mstatus_i[MSTATUS_MPIE];
            mstatus_o[MSTATUS_MPIE]                  = 1'b1;
            mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
        end
    end

endmodule : trap_mstatus_upd

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
// Trap sequencer owning the single write port of the machine-mode CSR file.
// Accepts ecall / mret / timer-interrupt events from writeback and performs
// the architectural updates one write per cycle (mepc, mcause, mstatus),
// then pulses a redirect to mtvec (trap) or mepc (return). Ordinary CSR
// instruction writes pass through only while no sequence is active.
// Ports:
//   clock            in   1     system clock
//   reset            in   1     asynchronous active-low reset
//   i_valid          in   1     writeback instruction valid
//   i_ecall          in   1     writeback instruction is ecall
//   i_mret           in   1     writeback instruction is mret
//   i_pc             in   XLEN  writeback pc
//   i_irq            in   1     machine timer interrupt request (level)
//   i_mstatus        in   XLEN  current mstatus
//   i_mtvec          in   XLEN  current mtvec
//   i_mepc           in   XLEN  current mepc
//   i_csrinst_wen    in   1     CSR instruction write request
//   i_csrinst_waddr  in   12    CSR instruction write address
//   i_csrinst_wdata  in   XLEN  CSR instruction write data
//   o_csrinst_ready  out  1     CSR instruction write accepted this cycle
//   o_csr_wen        out  1     CSR file write enable
//   o_csr_waddr      out  12    CSR file write address
//   o_csr_wdata      out  XLEN  CSR file write data
//   o_stall          out  1     hold front end and writeback
//   o_redirect       out  1     one-cycle flush/redirect pulse
//   o_redirect_pc    out  XLEN  redirect target
// ---------------------------------------------------------------------------
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(CAUSE_ECALL_M),
    parameter logic [XLEN-1:0] IRQ_CAUSE   = XLEN'(CAUSE_MTIMER),
    parameter logic [XLEN-1:0] MTVEC_MASK  = XLEN'(MTVEC_DIRECT_MASK)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_valid,
    input  logic            i_ecall,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_irq,
    input  logic [XLEN-1:0] i_mstatus,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_csrinst_wen,
    input  logic [11:0]     i_csrinst_waddr,
    input  logic [XLEN-1:0] i_csrinst_wdata,
    output logic            o_csrinst_ready,
    output logic            o_csr_wen,
    output logic [11:0]     o_csr_waddr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_stall,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);

    // -----------------------------------------------------------------------
    // State and latched event information
    // -----------------------------------------------------------------------
    trap_state_e     state_q, state_d;
    trap_kind_e      kind_q,  kind_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] cause_q, cause_d;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    logic mie_en;
    logic take_irq;
    logic take_ecall;
    logic take_mret;
    logic in_idle;
    logic accept;

    assign mie_en     = i_mstatus[MSTATUS_MIE];
    assign take_irq   = i_irq & mie_en & i_valid;
    assign take_ecall = i_valid & i_ecall;
    assign take_mret  = i_valid & i_mret;
    assign in_idle    = (state_q == IDLE);
    // Events are only looked at in IDLE; an irq rising mid-sequence waits.
    assign accept     = in_idle & (take_irq | take_ecall | take_mret);

    // -----------------------------------------------------------------------
    // mstatus rewrite for the W_STAT step, selected by the latched kind
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] mstatus_new;

    trap_mstatus_upd #(
        .XLEN (XLEN)
    ) u_mstatus_upd (
        .mstatus_i (i_mstatus),
        .kind_i    (kind_q),
        .mstatus_o (mstatus_new)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            kind_q  <= KIND_TRAP;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        pc_d    = pc_q;
        cause_d = cause_q;

        unique case (state_q)
            IDLE: begin
                // Priority: irq, then ecall, then mret (mret dropped if
                // it arrives together with ecall).
                if (take_irq) begin
                    state_d = W_EPC;
                    kind_d  = KIND_TRAP;
                    pc_d    = i_pc;      // interrupted instruction re-executes
                    cause_d = IRQ_CAUSE;
                end else if (take_ecall) begin
                    state_d = W_EPC;
                    kind_d  = KIND_TRAP;
                    pc_d    = i_pc;
                    cause_d = ECALL_CAUSE;
                end else if (take_mret) begin
                    // A return has no mepc/mcause writes; go straight to mstatus.
                    state_d = W_STAT;
                    kind_d  = KIND_RET;
                    pc_d    = i_pc;
                    cause_d = '0;
                end
            end
            W_EPC:   state_d = W_CAUSE;
            W_CAUSE: state_d = W_STAT;
            W_STAT:  state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic. Everything is forced to zero while reset is held, which
    // also keeps the pass-through from advertising ready during reset.
    // -----------------------------------------------------------------------
    always_comb begin
        o_csrinst_ready = 1'b0;
        o_csr_wen       = 1'b0;
        o_csr_waddr     = '0;
        o_csr_wdata     = '0;
        o_stall         = 1'b0;
        o_redirect      = 1'b0;
        o_redirect_pc   = '0;

        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    // Stall asserts combinationally on the acceptance cycle
                    // so the trapping instruction is held in writeback.
                    o_stall         = accept;
                    o_csrinst_ready = ~accept;
                    if (!accept && i_csrinst_wen) begin
                        o_csr_wen   = 1'b1;
                        o_csr_waddr = i_csrinst_waddr;
                        o_csr_wdata = i_csrinst_wdata;
                    end
                end
                W_EPC: begin
                    o_stall     = 1'b1;
                    o_csr_wen   = 1'b1;
                    o_csr_waddr = CSR_MEPC;
                    o_csr_wdata = pc_q;
                end
                W_CAUSE: begin
                    o_stall     = 1'b1;
                    o_csr_wen   = 1'b1;
                    o_csr_waddr = CSR_MCAUSE;
                    o_csr_wdata = cause_q;
                end
                W_STAT: begin
                    o_stall     = 1'b1;
                    o_csr_wen   = 1'b1;
                    o_csr_waddr = CSR_MSTATUS;
                    o_csr_wdata = mstatus_new;
                end
                REDIR: begin
                    o_stall       = 1'b1;
                    o_redirect    = 1'b1;
                    // mtvec/mepc are read live: the writes above have
                    // already landed in the CSR file by this cycle.
                    o_redirect_pc = (kind_q == KIND_TRAP) ? (i_mtvec & MTVEC_MASK)
                                                          : i_mepc;
                end
                default: begin
                    o_stall = 1'b1;
                end
            endcase
        end
    end

endmodule : trap_ctrl

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_valid = 1'b0, i_ecall = 1'b0, i_mret = 1'b0, i_irq = 1'b0;
    logic [31:0] i_pc = '0, i_mstatus = '0, i_mtvec = '0, i_mepc = '0;
    logic        i_csrinst_wen = 1'b0;
    logic [11:0] i_csrinst_waddr = '0;
    logic [31:0] i_csrinst_wdata = '0;
    logic        o_csrinst_ready, o_csr_wen, o_stall, o_redirect;
    logic [11:0] o_csr_waddr;
    logic [31:0] o_csr_wdata, o_redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    trap_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .i_valid         (i_valid),
        .i_ecall         (i_ecall),
        .i_mret          (i_mret),
        .i_pc            (i_pc),
        .i_irq           (i_irq),
        .i_mstatus       (i_mstatus),
        .i_mtvec         (i_mtvec),
        .i_mepc          (i_mepc),
        .i_csrinst_wen   (i_csrinst_wen),
        .i_csrinst_waddr (i_csrinst_waddr),
        .i_csrinst_wdata (i_csrinst_wdata),
        .o_csrinst_ready (o_csrinst_ready),
        .o_csr_wen       (o_csr_wen),
        .o_csr_waddr     (o_csr_waddr),
        .o_csr_wdata     (o_csr_wdata),
        .o_stall         (o_stall),
        .o_redirect      (o_redirect),
        .o_redirect_pc   (o_redirect_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // A sequence is a scripted list of future cycles, one entry per cycle.
    localparam int S_EPC = 0, S_CAUSE = 1, S_STAT_T = 2, S_STAT_R = 3, S_RED_T = 4, S_RED_R = 5;

    function automatic logic [31:0] m_trap(input logic [31:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_1800 | ((m & 32'h8) << 4);
    endfunction

    function automatic logic [31:0] m_ret(input logic [31:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_0080 | ((m & 32'h80) >> 4);
    endfunction

    bit          model_on = 0;
    int          sched[$];
    logic [31:0] m_pc, m_cause;
    logic        e_ready, e_wen, e_stall, e_redir, ev_irq, ev_ecall, ev_mret;
    logic [11:0] e_waddr;
    logic [31:0] e_wdata, e_rpc;

    always @(negedge clock) begin
        if (model_on) begin
            e_ready = 0; e_wen = 0; e_waddr = 0; e_wdata = 0;
            e_stall = 0; e_redir = 0; e_rpc = 0;
            ev_irq   = i_irq & i_mstatus[3] & i_valid;
            ev_ecall = i_valid & i_ecall;
            ev_mret  = i_valid & i_mret;
            if (reset) begin
                if (sched.size() == 0) begin
                    if (ev_irq | ev_ecall | ev_mret) begin
                        e_stall = 1;
                    end else begin
                        e_ready = 1;
                        if (i_csrinst_wen) begin
                            e_wen = 1; e_waddr = i_csrinst_waddr; e_wdata = i_csrinst_wdata;
                        end
                    end
                end else begin
                    e_stall = 1;
                    case (sched[0])
                        S_EPC:    begin e_wen = 1; e_waddr = 12'h341; e_wdata = m_pc;              end
                        S_CAUSE:  begin e_wen = 1; e_waddr = 12'h342; e_wdata = m_cause;           end
                        S_STAT_T: begin e_wen = 1; e_waddr = 12'h300; e_wdata = m_trap(i_mstatus); end
                        S_STAT_R: begin e_wen = 1; e_waddr = 12'h300; e_wdata = m_ret(i_mstatus);  end
                        S_RED_T:  begin e_redir = 1; e_rpc = i_mtvec & 32'hFFFF_FFFC;              end
                        default:  begin e_redir = 1; e_rpc = i_mepc;                               end
                    endcase
                end
            end
            check("m_ready", {31'd0, o_csrinst_ready}, {31'd0, e_ready});
            check("m_wen",   {31'd0, o_csr_wen},       {31'd0, e_wen});
            check("m_waddr", {20'd0, o_csr_waddr},     {20'd0, e_waddr});
            check("m_wdata", o_csr_wdata,              e_wdata);
            check("m_stall", {31'd0, o_stall},         {31'd0, e_stall});
            check("m_redir", {31'd0, o_redirect},      {31'd0, e_redir});
            check("m_rpc",   o_redirect_pc,            e_rpc);
            // advance the model across the coming clock edge
            if (!reset) begin
                sched.delete();
            end else if (sched.size() != 0) begin
                void'(sched.pop_front());
            end else if (ev_irq | ev_ecall) begin
                m_pc    = i_pc;
                m_cause = ev_irq ? 32'h8000_0007 : 32'd11;
                sched   = '{S_EPC, S_CAUSE, S_STAT_T, S_RED_T};
            end else if (ev_mret) begin
                sched = '{S_STAT_R, S_RED_R};
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_ecall = 0; i_mret = 0; i_irq = 0; i_csrinst_wen = 0;
    endtask

    int  waited;
    bit  got;

    initial begin
        // reset state, with requests present that must be ignored
        i_valid = 1; i_ecall = 1; i_csrinst_wen = 1; i_csrinst_waddr = 12'h123;
        i_csrinst_wdata = 32'h1234_5678;
        #12;
        check("rst_ready", {31'd0, o_csrinst_ready}, 32'd0);
        check("rst_wen",   {31'd0, o_csr_wen},       32'd0);
        check("rst_wdata", o_csr_wdata,              32'd0);
        check("rst_stall", {31'd0, o_stall},         32'd0);
        step();
        reset = 1; idle_inputs(); model_on = 1;

        // ecall trap
        step();
        i_valid = 1; i_ecall = 1; i_pc = 32'h8000_0100; i_mstatus = 32'h8; i_mtvec = 32'h8000_0503;
        @(negedge clock); check("ecall_stall", {31'd0, o_stall}, 32'd1);
        step(); idle_inputs();
        @(negedge clock); check("ecall_epc_a", {20'd0, o_csr_waddr}, 32'h341);
        check("ecall_epc_d", o_csr_wdata, 32'h8000_0100);
        step(); @(negedge clock); check("ecall_cause", o_csr_wdata, 32'd11);
        step(); @(negedge clock); check("ecall_stat", o_csr_wdata, 32'h1880);
        step(); @(negedge clock); check("ecall_redir", {31'd0, o_redirect}, 32'd1);
        check("ecall_rpc", o_redirect_pc, 32'h8000_0500);
        step(); @(negedge clock); check("ecall_redir_done", {31'd0, o_redirect}, 32'd0);

        // mret
        step();
        i_valid = 1; i_mret = 1; i_mstatus = 32'h1880; i_mepc = 32'h8000_0104;
        @(negedge clock); check("mret_stall", {31'd0, o_stall}, 32'd1);
        step(); idle_inputs();
        @(negedge clock); check("mret_stat", o_csr_wdata, 32'h88);
        step(); @(negedge clock); check("mret_rpc", o_redirect_pc, 32'h8000_0104);

        // timer interrupt, enabled; irq stays high through the sequence
        step();
        i_valid = 1; i_irq = 1; i_mstatus = 32'h8; i_pc = 32'h200;
        @(negedge clock);
        step(); i_valid = 0;
        @(negedge clock); check("irq_epc", o_csr_wdata, 32'h200);
        step(); @(negedge clock); check("irq_cause", o_csr_wdata, 32'h8000_0007);
        step(); @(negedge clock); check("irq_stat", o_csr_wdata, 32'h1880);
        step(); @(negedge clock); check("irq_rpc", o_redirect_pc, 32'h8000_0500);
        // interrupt disabled: nothing happens
        step();
        i_valid = 1; i_irq = 1; i_mstatus = 32'h0;
        @(negedge clock); check("irq_off_stall", {31'd0, o_stall}, 32'd0);
        check("irq_off_ready", {31'd0, o_csrinst_ready}, 32'd1);
        step(); idle_inputs();

        // ecall + mret together, CSR write held from W_CAUSE
        step();
        i_valid = 1; i_ecall = 1; i_mret = 1; i_pc = 32'h400; i_mstatus = 32'h8;
        @(negedge clock);
        step(); idle_inputs();
        @(negedge clock); check("both_first_addr", {20'd0, o_csr_waddr}, 32'h341);
        step();
        i_csrinst_wen = 1; i_csrinst_waddr = 12'h305; i_csrinst_wdata = 32'hDEAD_BEEF;
        @(negedge clock); check("hold_ready", {31'd0, o_csrinst_ready}, 32'd0);
        check("hold_addr", {20'd0, o_csr_waddr}, 32'h342);
        got = 0; waited = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            step(); waited++;
            @(negedge clock);
            if (o_csrinst_ready) begin
                got = 1;
                check("hold_wr_addr", {20'd0, o_csr_waddr}, 32'h305);
                check("hold_wr_data", o_csr_wdata, 32'hDEAD_BEEF);
            end
        end
        check("hold_accepted", {31'd0, got}, 32'd1);
        check("hold_cycles", waited, 32'd3);
        step(); i_csrinst_wen = 0;
        @(negedge clock); check("hold_once", {31'd0, o_csr_wen}, 32'd0);

        // reset in W_CAUSE
        step();
        i_valid = 1; i_ecall = 1; i_pc = 32'h600;
        @(negedge clock);
        step(); idle_inputs();
        @(negedge clock);
        step();
        #2; reset = 0; i_csrinst_wen = 1;
        #1;
        check("abort_wen",   {31'd0, o_csr_wen},       32'd0);
        check("abort_waddr", {20'd0, o_csr_waddr},     32'd0);
        check("abort_stall", {31'd0, o_stall},         32'd0);
        check("abort_ready", {31'd0, o_csrinst_ready}, 32'd0);
        step(); reset = 1; i_csrinst_wen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("abort_no_redir", {31'd0, o_redirect}, 32'd0);
            check("abort_no_wen",   {31'd0, o_csr_wen},  32'd0);
            step();
        end

        // randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            step();
            reset           = ($urandom_range(0, 199) != 0);
            i_valid         = ($urandom_range(0, 1) == 1);
            i_ecall         = ($urandom_range(0, 3) == 0);
            i_mret          = ($urandom_range(0, 3) == 0);
            i_irq           = ($urandom_range(0, 2) == 0);
            i_pc            = $urandom;
            i_mstatus       = $urandom;
            i_mtvec         = $urandom;
            i_mepc          = $urandom;
            i_csrinst_wen   = ($urandom_range(0, 1) == 1);
            i_csrinst_waddr = 12'($urandom);
            i_csrinst_wdata = $urandom;
        end

        step(); idle_inputs(); reset = 1;
        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_trap_ctrl
